// File: rtl/alu_op_issuer_if.sv
// alu_op_issuer_if: request, ALU and response signals of the ALU operation issuer.
interface alu_op_issuer_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  alu_opcode;
    logic [31:0] alu_ra;
    logic [31:0] alu_rb;
    logic [31:0] alu_zhi;
    logic [31:0] alu_zlo;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_hi;
    logic [31:0] rsp_lo;
    logic        rsp_err;
    logic        busy;
    modport slave (
        input  req_valid, req_op, req_a, req_b, alu_zhi, alu_zlo, rsp_ready,
        output req_ready, alu_opcode, alu_ra, alu_rb, rsp_valid, rsp_hi, rsp_lo, rsp_err, busy
    );
    modport master (
        output req_valid, req_op, req_a, req_b, alu_zhi, alu_zlo, rsp_ready,
        input  req_ready, alu_opcode, alu_ra, alu_rb, rsp_valid, rsp_hi, rsp_lo, rsp_err, busy
    );
endinterface

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: latches an ALU op, waits the settle time, captures HI/LO into a response.
// Define DIV_ZERO_TRAP_EN to trap Divide with Rb=0 as an error response.
module alu_op_issuer #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned MULDIV_CYCLES = 4
) (
    input logic           clk,
    input logic           reset,
    alu_op_issuer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  op_q, op_d;
    logic [31:0] ra_q, ra_d, rb_q, rb_d, hi_q, hi_d, lo_q, lo_d;
    logic        err_q, err_d, bad_q, bad_d;
    logic        legal, muldiv, trap, bad_in;
    logic [3:0]  load_cnt;
    assign legal  = bus.req_op inside {[5'd3:5'd10], [5'd14:5'd17]};
    assign muldiv = bus.req_op == 5'd14 || bus.req_op == 5'd15;
`ifdef DIV_ZERO_TRAP_EN
    assign trap   = bus.req_op == 5'd15 && bus.req_b == 32'd0;
`else
    assign trap   = 1'b0;
`endif
    assign bad_in   = !legal || trap;
    assign load_cnt = bad_in ? 4'd1 : muldiv ? 4'(MULDIV_CYCLES) : 4'(SETTLE_CYCLES);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        err_d   = err_q;
        bad_d   = bad_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                state_d = WAIT;
                cnt_d   = load_cnt;
                op_d    = bus.req_op;
                ra_d    = bus.req_a;
                rb_d    = bus.req_b;
                bad_d   = bad_in;
            end
            WAIT: if (cnt_q <= 4'd1) begin
                state_d = RESP;
                cnt_d   = 4'd0;
                hi_d    = bad_q ? 32'd0 : bus.alu_zhi;
                lo_d    = bad_q ? 32'd0 : bus.alu_zlo;
                err_d   = bad_q;
            end else begin
                cnt_d   = cnt_q - 4'd1;
            end
            RESP: state_d = bus.rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            err_q   <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
            bad_q   <= bad_d;
        end
    end
    assign bus.req_ready  = state_q == IDLE;
    assign bus.rsp_valid  = state_q == RESP;
    assign bus.busy       = state_q != IDLE;
    assign bus.alu_opcode = op_q;
    assign bus.alu_ra     = ra_q;
    assign bus.alu_rb     = rb_q;
    assign bus.rsp_hi     = hi_q;
    assign bus.rsp_lo     = lo_q;
    assign bus.rsp_err    = err_q;
endmodule

// File: tb/tb_alu_op_issuer.sv
// tb_alu_op_issuer: directed and random ops against a behavioural ALU/issuer model.
module tb_alu_op_issuer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    alu_op_issuer_if bus ();
    alu_op_issuer dut (.clk(clk), .reset(reset), .bus(bus));
`ifdef DIV_ZERO_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    int n_chk = 0;
    int n_fail = 0;
    function automatic logic [63:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'd3:  alu_model = {32'd0, a + b};
            5'd4:  alu_model = {32'd0, a - b};
            5'd5:  alu_model = {32'd0, a & b};
            5'd6:  alu_model = {32'd0, a | b};
            5'd7:  alu_model = {32'd0, a ^ b};
            5'd8:  alu_model = {32'd0, a << b[4:0]};
            5'd9:  alu_model = {32'd0, a >> b[4:0]};
            5'd10: alu_model = {63'd0, $signed(a) < $signed(b)};
            5'd14: alu_model = {32'd0, a} * {32'd0, b};
            5'd15: alu_model = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            5'd16: alu_model = {b, a};
            5'd17: alu_model = {~a, ~b};
            default: alu_model = {a | 32'h1, b | 32'h1};
        endcase
    endfunction
    logic [63:0] z;
    assign z = alu_model(bus.alu_opcode, bus.alu_ra, bus.alu_rb);
    assign bus.alu_zhi = z[63:32];
    assign bus.alu_zlo = z[31:0];
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        int lat;
        int exp_lat;
        logic bad;
        logic [63:0] exp_z;
        bad = !(op inside {[5'd3:5'd10], [5'd14:5'd17]}) || (TRAP && op == 5'd15 && b == 32'd0);
        exp_lat = bad ? 1 : (op == 5'd14 || op == 5'd15) ? 4 : 1;
        exp_z = bad ? 64'd0 : alu_model(op, a, b);
        @(negedge clk);
        chk("idle_ready", {bus.req_ready, bus.busy, bus.rsp_valid}, 3'b100);
        bus.req_valid = 1'b1;
        bus.req_op = op;
        bus.req_a = a;
        bus.req_b = b;
        @(negedge clk);
        bus.req_op = op ^ 5'h5;
        bus.req_a = ~a;
        bus.req_b = b + 32'd3;
        chk("latched", {bus.alu_opcode, bus.alu_ra, bus.alu_rb}, {op, a, b});
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 128'(lat), 128'(exp_lat));
        chk("rsp", {bus.rsp_hi, bus.rsp_lo, bus.rsp_err}, {exp_z, bad});
        repeat (hold) begin
            @(negedge clk);
            chk("hold_rsp", {bus.rsp_valid, bus.req_ready, bus.rsp_hi, bus.rsp_lo, bus.rsp_err}, {2'b10, exp_z, bad});
            chk("hold_alu", {bus.alu_opcode, bus.alu_ra, bus.alu_rb}, {op, a, b});
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        chk("after_hs", {bus.rsp_valid, bus.req_ready, bus.busy, bus.rsp_hi, bus.rsp_lo, bus.rsp_err}, {3'b010, exp_z, bad});
        chk("after_hs_alu", {bus.alu_opcode, bus.alu_ra, bus.alu_rb}, {op, a, b});
    endtask
    initial begin
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op = 5'd0;
        bus.req_a = 32'd0;
        bus.req_b = 32'd0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_alu", {bus.alu_opcode, bus.alu_ra, bus.alu_rb}, 69'd0);
        chk("reset_rsp", {bus.rsp_hi, bus.rsp_lo, bus.rsp_err, bus.rsp_valid, bus.busy, bus.req_ready}, {67'd0, 1'b1});
        reset = 1'b0;
        run_op(5'd3, 32'd5, 32'd7, 0);
        run_op(5'd14, 32'h10000, 32'h10000, 2);
        run_op(5'd0, 32'h1234, 32'h5678, 0);
        run_op(5'd31, 32'hDEAD, 32'hBEEF, 1);
        run_op(5'd7, 32'hF0F0_1234, 32'h0FF0_4321, 5);
        run_op(5'd15, 32'd100, 32'd0, 1);
        run_op(5'd15, 32'd100, 32'd7, 0);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op = 5'd14;
        bus.req_a = 32'hFFFF_FFFF;
        bus.req_b = 32'h2;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midwait_reset_alu", {bus.alu_opcode, bus.alu_ra, bus.alu_rb}, 69'd0);
        chk("midwait_reset_rsp", {bus.rsp_hi, bus.rsp_lo, bus.rsp_err, bus.rsp_valid, bus.busy, bus.req_ready}, {67'd0, 1'b1});
        repeat (5) begin
            @(negedge clk);
            chk("no_rsp_after_reset", {bus.rsp_valid, bus.busy}, 2'b00);
        end
        run_op(5'd4, 32'd50, 32'd8, 1);
        for (int i = 0; i < 40; i++) begin
            logic [4:0] op;
            logic [31:0] a, b;
            op = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(14, 15));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            run_op(op, a, b, int'($urandom_range(0, 3)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_op_issuer.md
ALU_OP_ISSUER -- requirements
Module: alu_op_issuer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1: ALU settle wait in cycles for single-word ops; legal range 1-15.
REQ-002 Parameter MULDIV_CYCLES, default 4: ALU settle wait in cycles for Multiply (5'b01110) and Divide (5'b01111); legal range 1-15.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  the requester presents an operation.
REQ-006 req_ready  out  1  the block accepts an operation this cycle.
REQ-007 req_op  in  5  ALU opcode.
REQ-008 req_a  in  32  operand Ra.
REQ-009 req_b  in  32  operand Rb.
REQ-010 alu_opcode  out  5  registered opcode driven to the ALU.
REQ-011 alu_ra  out  32  registered Ra driven to the ALU.
REQ-012 alu_rb  out  32  registered Rb driven to the ALU.
REQ-013 alu_zhi  in  32  ALU high result word.
REQ-014 alu_zlo  in  32  ALU low result word.
REQ-015 rsp_valid  out  1  a captured result is presented.
REQ-016 rsp_ready  in  1  the consumer takes the result.
REQ-017 rsp_hi  out  32  captured high word (HI register value).
REQ-018 rsp_lo  out  32  captured low word (LO register value).
REQ-019 rsp_err  out  1  illegal opcode, or trapped divide-by-zero.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 The FSM SHALL have states IDLE, WAIT, RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-022 In IDLE with req_valid=1, the block SHALL latch req_op/req_a/req_b into alu_opcode/alu_ra/alu_rb at that edge and enter WAIT.
REQ-023 Legal opcodes SHALL be 3-10, 14, 15, 16 and 17 (decimal); all other opcodes are illegal.
REQ-024 On accept, the 4-bit wait counter SHALL load MULDIV_CYCLES for opcodes 14/15, SETTLE_CYCLES for other legal opcodes, and 1 for illegal opcodes.
REQ-025 In WAIT, the counter SHALL decrement by 1 each cycle while it is >1; at the edge where it equals 1, the block SHALL capture the result and enter RESP.
REQ-026 Latency: rsp_valid SHALL first be high exactly N cycles after the accept edge (N = loaded count).
REQ-027 Legal op capture: rsp_hi=alu_zhi, rsp_lo=alu_zlo, rsp_err=0.
REQ-028 Illegal op capture: rsp_hi=0, rsp_lo=0, rsp_err=1.
REQ-029 alu_opcode/alu_ra/alu_rb SHALL hold stable from accept until the next accept; they SHALL not change in WAIT or RESP.
REQ-030 In RESP, rsp_hi/rsp_lo/rsp_err SHALL hold stable until rsp_ready=1; on that edge the block SHALL return to IDLE, and those outputs SHALL keep their values.
REQ-031 A request SHALL NOT be accepted in the same cycle as a response handshake; the earliest next accept is the cycle after RESP exits.
REQ-032 req_valid asserted outside IDLE SHALL be ignored, without latching.

Reset
REQ-033 reset=1 SHALL force IDLE, counter=0, and zero on alu_opcode, alu_ra, alu_rb, rsp_hi, rsp_lo, rsp_err, rsp_valid and busy, with req_ready=1 at the next edge.
REQ-034 Reset in WAIT or RESP SHALL abandon the operation with no response issued; reset takes priority over every handshake.

Configuration
REQ-035 Macro DIV_ZERO_TRAP_EN, when defined: an accepted Divide (14... opcode 15) with req_b=0 SHALL load count 1 and capture rsp_hi=0, rsp_lo=0, rsp_err=1.
REQ-036 Without DIV_ZERO_TRAP_EN: Divide with req_b=0 SHALL be handled as a legal opcode (MULDIV_CYCLES wait, ALU words captured, rsp_err=0).

Verification
REQ-037 Reset, then Addition op=3, a=5, b=7, ALU model returns ZLO=12 -> rsp_valid high 1 cycle after accept, rsp_lo=12, rsp_hi=0, rsp_err=0.
REQ-038 Multiply op=14, a=32'h10000, b=32'h10000, MULDIV_CYCLES=4 -> rsp_valid 4 cycles after accept, rsp_hi=1, rsp_lo=0.
REQ-039 Illegal op=0 and op=31 -> each responds after 1 cycle with rsp_err=1, rsp_hi=rsp_lo=0.
REQ-040 Hold rsp_ready=0 for 5 cycles in RESP while driving new req_valid -> response stable, req_ready=0, no new latch; rsp_ready=1 -> IDLE next cycle.
REQ-041 Divide op=15, b=0: with DIV_ZERO_TRAP_EN -> rsp_err=1 after 1 cycle; without it -> rsp_err=0 after 4 cycles.
REQ-042 Reset asserted during the 2nd WAIT cycle of a Multiply -> all outputs zero, no rsp_valid, next request processed normally.
